// File: rtl/net_strength_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : net_strength_pkg                                             |
// | Description : Strength/value types shared by the net strength resolver.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package net_strength_pkg;

    typedef enum logic [2:0] {
        HIGHZ  = 3'd0,
        SMALL  = 3'd1,
        MEDIUM = 3'd2,
        WEAK   = 3'd3,
        LARGE  = 3'd4,
        PULL   = 3'd5,
        STRONG = 3'd6,
        SUPPLY = 3'd7
    } strength_e;

    typedef enum logic [1:0] {
        L0 = 2'b00,
        L1 = 2'b01,
        LX = 2'b10,
        LZ = 2'b11
    } logic4_e;

    typedef struct packed {
        logic4_e   val;
        strength_e str;
    } res_t;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    localparam res_t c_RES_Z = '{val: LZ, str: HIGHZ};

endpackage

`default_nettype wire

// File: rtl/net_strength_resolver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : net_strength_resolver_if                                     |
// | Description : Driver-beat stream in, resolved-net result out.              |
// |               res_conflict exists only with NET_STRENGTH_RESOLVER_CONFLICT_EN.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface net_strength_resolver_if #(
    parameter int CNT_W = 4
);
    logic             drv_valid;
    logic             drv_ready;
    logic             drv_val;
    logic [2:0]       drv_str0;
    logic [2:0]       drv_str1;
    logic             drv_last;
    logic             res_valid;
    logic             res_ready;
    logic [1:0]       res_val;
    logic [2:0]       res_str;
    logic [CNT_W-1:0] res_ndrv;
    logic             res_ovf;
`ifdef NET_STRENGTH_RESOLVER_CONFLICT_EN
    logic             res_conflict;
`endif

    modport master (
        output drv_valid, drv_val, drv_str0, drv_str1, drv_last, res_ready,
`ifdef NET_STRENGTH_RESOLVER_CONFLICT_EN
        input  res_conflict,
`endif
        input  drv_ready, res_valid, res_val, res_str, res_ndrv, res_ovf
    );

    modport slave (
        input  drv_valid, drv_val, drv_str0, drv_str1, drv_last, res_ready,
`ifdef NET_STRENGTH_RESOLVER_CONFLICT_EN
        output res_conflict,
`endif
        output drv_ready, res_valid, res_val, res_str, res_ndrv, res_ovf
    );

endinterface

`default_nettype wire

// File: rtl/net_strength_merge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : net_strength_merge                                           |
// | Description : Combinational merge of one driver contribution into a       |
// |               running (value, strength) accumulator.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module net_strength_merge
    import net_strength_pkg::*;
(
    input  res_t      i_acc,
    input  logic      i_cv,
    input  strength_e i_cs,
    output res_t      o_nxt
);

    logic4_e w_cval;

    always_comb begin
        w_cval = i_cv ? L1 : L0;
        o_nxt  = i_acc;
        if (i_cs != HIGHZ) begin
            if ((i_acc.val == LZ) || (i_cs > i_acc.str)) begin
                o_nxt.val = w_cval;
                o_nxt.str = i_cs;
            end else if ((i_cs == i_acc.str) && (i_acc.val != w_cval)) begin
                // Equal-strength disagreement, or anything meeting an X, stays X.
                o_nxt.val = LX;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/net_strength_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : net_strength_resolver                                        |
// | Description : Resolves a framed stream of driver beats into one 4-state    |
// |               value + strength. Option: NET_STRENGTH_RESOLVER_CONFLICT_EN. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module net_strength_resolver
    import net_strength_pkg::*;
#(
    parameter int MAX_DRIVERS = 8,
    parameter int CNT_W       = $clog2(MAX_DRIVERS + 1)
) (
    input wire logic               clk,
    input wire logic               rst_n,
    net_strength_resolver_if.slave bus
);

    localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX_DRIVERS);

    state_e           r_state;
    state_e           w_state_nxt;
    res_t             r_acc;
    res_t             w_merged;
    strength_e        w_cs;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             w_accept;
    logic             w_release;

    assign w_accept  = bus.drv_valid && (r_state == ST_ACCUM);
    assign w_release = bus.res_ready && (r_state == ST_HOLD);
    assign w_cs      = bus.drv_val ? strength_e'(bus.drv_str1) : strength_e'(bus.drv_str0);

    net_strength_merge u_merge (
        .i_acc (r_acc),
        .i_cv  (bus.drv_val),
        .i_cs  (w_cs),
        .o_nxt (w_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_ACCUM;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACCUM: if (w_accept && bus.drv_last) w_state_nxt = ST_HOLD;
            ST_HOLD:  if (bus.res_ready)            w_state_nxt = ST_ACCUM;
            default:                                w_state_nxt = ST_ACCUM;
        endcase
    end

    // The accumulator doubles as the result register: nothing merges while in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= c_RES_Z;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_release) begin
            r_acc <= c_RES_Z;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_merged;
            if (r_cnt == c_MAX) r_ovf <= 1'b1;
            else                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.drv_ready = (r_state == ST_ACCUM);
    assign bus.res_valid = (r_state == ST_HOLD);
    assign bus.res_val   = r_acc.val;
    assign bus.res_str   = r_acc.str;
    assign bus.res_ndrv  = r_cnt;
    assign bus.res_ovf   = r_ovf;

`ifdef NET_STRENGTH_RESOLVER_CONFLICT_EN
    logic r_seen0;
    logic r_seen1;
    logic r_conflict;
    logic w_seen0;
    logic w_seen1;

    assign w_seen0 = r_seen0 || ((w_cs != HIGHZ) && !bus.drv_val);
    assign w_seen1 = r_seen1 || ((w_cs != HIGHZ) &&  bus.drv_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen0    <= 1'b0;
            r_seen1    <= 1'b0;
            r_conflict <= 1'b0;
        end else if (w_release) begin
            r_seen0    <= 1'b0;
            r_seen1    <= 1'b0;
            r_conflict <= 1'b0;
        end else if (w_accept) begin
            r_seen0 <= w_seen0;
            r_seen1 <= w_seen1;
            if (bus.drv_last)
                r_conflict <= (w_merged.val == LX) ||
                              ((w_merged.val == L0) && w_seen1) ||
                              ((w_merged.val == L1) && w_seen0);
        end
    end

    assign bus.res_conflict = r_conflict;
`endif

endmodule

`default_nettype wire
